// File: rtl/otus_hist_scan.sv
`default_nettype none
// ============================================================================
// Module   : otus_hist_scan
// Brief    : Sweeps all 128 thresholds of an accumulated gray histogram and
//            feeds cumulative counts / gray-weighted sums on both sides of
//            each threshold to the Otsu DSP stage at a fixed 128-cycle period.
//            Clears every histogram bin as it goes and closes the sweep
//            with a single finish_clear pulse.
// Revision : 1.0 - initial release
// ============================================================================
module otus_hist_scan #(
    parameter int BIN_W  = 20,
    parameter int GA_W   = 23,
    parameter int PERIOD = 128
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [6:0]       ram_rd_addr,
    input  logic [BIN_W-1:0] ram_rd_data,
    output logic             ram_wr_en,
    output logic [6:0]       ram_wr_addr,
    output logic [BIN_W-1:0] ram_wr_data,
    output logic             dsp_vld,
    output logic [BIN_W-1:0] N1_u20,
    output logic [BIN_W-1:0] N2_u20,
    output logic [GA_W-1:0]  GrayAll1,
    output logic [GA_W-1:0]  GrayAll2,
    output logic             finish_clear
);

    // Sweep phases: total accumulation, per-threshold emission, tail delay.
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_TOTAL = 2'd1;
    localparam logic [1:0] c_S_EMIT  = 2'd2;
    localparam logic [1:0] c_S_TAIL  = 2'd3;

    // Last cycle index inside one emission window (window length = PERIOD).
    localparam logic [6:0] c_LAST_CYC = 7'(PERIOD - 1);
    localparam logic [6:0] c_LAST_BIN = 7'd127;

    logic [1:0]       r_state;
    logic [7:0]       r_cnt;        // TOTAL: cycle index 0..128, TAIL: 0..1
    logic [6:0]       r_win;        // threshold T under emission
    logic [6:0]       r_cyc;        // cycle index inside the current window
    logic [BIN_W-1:0] r_h;          // bin value captured for the current window
    logic [BIN_W-1:0] r_ntot;
    logic [GA_W-1:0]  r_gatot;
    logic [BIN_W-1:0] r_n1;
    logic [GA_W-1:0]  r_ga1;

    logic             r_busy;
    logic [6:0]       r_rd_addr;
    logic             r_wr_en;
    logic [6:0]       r_wr_addr;
    logic             r_dsp_vld;
    logic [BIN_W-1:0] r_n1_out;
    logic [BIN_W-1:0] r_n2_out;
    logic [GA_W-1:0]  r_ga1_out;
    logic [GA_W-1:0]  r_ga2_out;
    logic             r_finish;

    logic [6:0]       w_tot_idx;
    logic [BIN_W-1:0] w_mul_a;
    logic [6:0]       w_mul_b;
    logic [GA_W-1:0]  w_prod;
    logic [BIN_W-1:0] w_n1_next;
    logic [GA_W-1:0]  w_ga1_next;

    // Data returned during TOTAL belongs to the address issued one cycle
    // earlier, so the gray weight is the cycle index minus one.
    assign w_tot_idx = r_cnt[6:0] - 7'd1;

    // One bin*gray multiplier shared by the TOTAL and EMIT phases; the full
    // BIN_W+7 product is formed before truncation to GA_W.
    assign w_mul_a    = (r_state == c_S_TOTAL) ? ram_rd_data : r_h;
    assign w_mul_b    = (r_state == c_S_TOTAL) ? w_tot_idx   : r_win;
    assign w_prod     = GA_W'({{7{1'b0}}, w_mul_a} * {{BIN_W{1'b0}}, w_mul_b});
    assign w_n1_next  = r_n1 + r_h;
    assign w_ga1_next = r_ga1 + w_prod;

    // Sweep sequencer: totals, per-window emission/clear, and finish timing.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= '0;
            r_win     <= '0;
            r_cyc     <= '0;
            r_h       <= '0;
            r_ntot    <= '0;
            r_gatot   <= '0;
            r_n1      <= '0;
            r_ga1     <= '0;
            r_busy    <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_dsp_vld <= 1'b0;
            r_n1_out  <= '0;
            r_n2_out  <= '0;
            r_ga1_out <= '0;
            r_ga2_out <= '0;
            r_finish  <= 1'b0;
        end else begin
            r_dsp_vld <= 1'b0;
            r_wr_en   <= 1'b0;
            r_finish  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state   <= c_S_TOTAL;
                        r_busy    <= 1'b1;
                        r_rd_addr <= '0;
                        r_cnt     <= '0;
                        r_ntot    <= '0;
                        r_gatot   <= '0;
                    end
                end
                c_S_TOTAL: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt < 8'd127) begin
                        r_rd_addr <= r_rd_addr + 7'd1;
                    end
                    if (r_cnt != 8'd0) begin
                        r_ntot  <= r_ntot + ram_rd_data;
                        r_gatot <= r_gatot + w_prod;
                    end
                    if (r_cnt == 8'd128) begin
                        r_state   <= c_S_EMIT;
                        r_win     <= '0;
                        r_cyc     <= '0;
                        r_rd_addr <= '0;
                        r_n1      <= '0;
                        r_ga1     <= '0;
                    end
                end
                c_S_EMIT: begin
                    r_cyc <= r_cyc + 7'd1;
                    if (r_cyc == 7'd1) begin
                        r_h <= ram_rd_data;
                    end
                    if (r_cyc == 7'd2) begin
                        r_n1      <= w_n1_next;
                        r_ga1     <= w_ga1_next;
                        r_n1_out  <= w_n1_next;
                        r_n2_out  <= r_ntot - w_n1_next;
                        r_ga1_out <= w_ga1_next;
                        r_ga2_out <= r_gatot - w_ga1_next;
                        r_dsp_vld <= 1'b1;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_win;
                    end
                    if (r_cyc == c_LAST_CYC) begin
                        if (r_win == c_LAST_BIN) begin
                            r_state <= c_S_TAIL;
                            r_cnt   <= '0;
                        end else begin
                            r_win     <= r_win + 7'd1;
                            r_rd_addr <= r_win + 7'd1;
                        end
                    end
                end
                c_S_TAIL: begin
                    // Two-cycle tail lands finish_clear on the DSP's
                    // final-window cycle 125; busy falls right after it.
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == 8'd0) begin
                        r_finish <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign ram_rd_addr  = r_rd_addr;
    assign ram_wr_en    = r_wr_en;
    assign ram_wr_addr  = r_wr_addr;
    assign ram_wr_data  = '0;
    assign dsp_vld      = r_dsp_vld;
    assign N1_u20       = r_n1_out;
    assign N2_u20       = r_n2_out;
    assign GrayAll1     = r_ga1_out;
    assign GrayAll2     = r_ga2_out;
    assign finish_clear = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_otus_hist_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_otus_hist_scan
// Brief    : Scoreboard bench for otus_hist_scan with a histogram RAM model
//            and a prefix-sum reference computed per sweep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_otus_hist_scan;

    localparam int BIN_W = 20;
    localparam int GA_W  = 23;

    logic             clock = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic [6:0]       ram_rd_addr;
    logic [BIN_W-1:0] ram_rd_data;
    logic             ram_wr_en;
    logic [6:0]       ram_wr_addr;
    logic [BIN_W-1:0] ram_wr_data;
    logic             dsp_vld;
    logic [BIN_W-1:0] N1_u20;
    logic [BIN_W-1:0] N2_u20;
    logic [GA_W-1:0]  GrayAll1;
    logic [GA_W-1:0]  GrayAll2;
    logic             finish_clear;

    otus_hist_scan #(.BIN_W(BIN_W), .GA_W(GA_W), .PERIOD(128)) dut (
        .clock        (clock),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .dsp_vld      (dsp_vld),
        .N1_u20       (N1_u20),
        .N2_u20       (N2_u20),
        .GrayAll1     (GrayAll1),
        .GrayAll2     (GrayAll2),
        .finish_clear (finish_clear)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Histogram RAM: 1-cycle read latency, bench loader port, DUT clear port.
    logic [BIN_W-1:0] mem [128];
    logic             ld_en = 1'b0;
    logic [6:0]       ld_addr = '0;
    logic [BIN_W-1:0] ld_data = '0;
    always @(posedge clock) begin
        ram_rd_data <= mem[ram_rd_addr];
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end

    typedef struct {
        logic [BIN_W-1:0] n1;
        logic [BIN_W-1:0] n2;
        logic [GA_W-1:0]  g1;
        logic [GA_W-1:0]  g2;
        int               t;
        int               k;
    } exp_t;

    exp_t             sb[$];
    int               fin_q[$];
    logic [BIN_W-1:0] hist [128];
    logic [6:0]       rd_hist [4];
    exp_t             mon_e;
    int n_checks = 0;
    int n_pass   = 0;
    int n_vld    = 0;
    int n_wr     = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pops the scoreboard on every dsp_vld / finish_clear.
    always @(negedge clock) begin
        if (dsp_vld && finish_clear) check("vld_fc_overlap", 1, 0);
        if (dsp_vld) begin
            n_vld++;
            if (sb.size() == 0) begin
                check("unexpected_vld", cyc, -1);
            end else begin
                mon_e = sb.pop_front();
                check("vld_time", cyc, mon_e.t);
                check("N1", N1_u20, mon_e.n1);
                check("N2", N2_u20, mon_e.n2);
                check("GA1", GrayAll1, mon_e.g1);
                check("GA2", GrayAll2, mon_e.g2);
                check("wr_with_vld", ram_wr_en, 1);
                check("wr_addr", ram_wr_addr, mon_e.k);
                check("rd_addr_3_before_wr", rd_hist[(cyc + 1) % 4], mon_e.k);
            end
        end
        if (ram_wr_en) begin
            n_wr++;
            check("wr_data", ram_wr_data, 0);
            if (!dsp_vld) check("wr_outside_c3", dsp_vld, 1);
        end
        if (finish_clear) begin
            if (fin_q.size() == 0) check("unexpected_fc", cyc, -1);
            else check("fc_time", cyc, fin_q.pop_front());
        end
        rd_hist[cyc % 4] = ram_rd_addr;
    end

    task automatic load_hist();
        for (int g = 0; g < 128; g++) begin
            @(negedge clock);
            ld_en   = 1'b1;
            ld_addr = 7'(g);
            ld_data = hist[g];
        end
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    // Reference: prefix sums of the histogram, one entry per threshold.
    task automatic push_expect(input int s);
        logic [BIN_W-1:0] ntot = '0;
        logic [BIN_W-1:0] n1   = '0;
        logic [GA_W-1:0]  gtot = '0;
        logic [GA_W-1:0]  g1   = '0;
        exp_t e;
        for (int g = 0; g < 128; g++) begin
            ntot = ntot + hist[g];
            gtot = gtot + GA_W'(longint'(hist[g]) * g);
        end
        for (int k = 0; k < 128; k++) begin
            n1   = n1 + hist[k];
            g1   = g1 + GA_W'(longint'(hist[k]) * k);
            e.n1 = n1;
            e.n2 = ntot - n1;
            e.g1 = g1;
            e.g2 = gtot - g1;
            e.t  = s + 133 + 128 * k;
            e.k  = k;
            sb.push_back(e);
        end
        fin_q.push_back(s + 16515);
    endtask

    // Caller is at a negedge; start is high for the current cycle s.
    task automatic pulse_start(output int s);
        s     = cyc;
        start = 1'b1;
        push_expect(s);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_cycle(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic check_all_zero();
        check("z_busy", busy, 0);
        check("z_dsp_vld", dsp_vld, 0);
        check("z_finish_clear", finish_clear, 0);
        check("z_wr_en", ram_wr_en, 0);
        check("z_rd_addr", ram_rd_addr, 0);
        check("z_N1", N1_u20, 0);
        check("z_N2", N2_u20, 0);
        check("z_GA1", GrayAll1, 0);
        check("z_GA2", GrayAll2, 0);
    endtask

    task automatic full_sweep(input bit mid_start);
        int s;
        int v0 = n_vld;
        int w0 = n_wr;
        int bad = 0;
        pulse_start(s);
        if (mid_start) begin
            wait_cycle(s + 3000);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        wait_cycle(s + 16515);
        check("busy_at_fc", busy, 1);
        check("fc_high", finish_clear, 1);
        @(negedge clock);
        check("busy_low_after_fc", busy, 0);
        check("pulse_count", n_vld - v0, 128);
        check("write_count", n_wr - w0, 128);
        check("sb_drained", sb.size() + fin_q.size(), 0);
        for (int g = 0; g < 128; g++) if (mem[g] !== '0) bad++;
        check("ram_nonzero_bins", bad, 0);
        for (int g = 0; g < 128; g++) hist[g] = '0;
    endtask

    // Start a sweep, then assert rst (together with start) at window w, c=1.
    task automatic abort_run(input int w);
        int s;
        int v0 = n_vld;
        int bad = 0;
        pulse_start(s);
        wait_cycle(s + 131 + 128 * w);
        rst   = 1'b1;
        start = 1'b1;
        sb.delete();
        fin_q.delete();
        @(negedge clock);
        check_all_zero();
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("idle_after_abort", busy, 0);
        check("abort_pulse_count", n_vld - v0, w);
        for (int g = 0; g < w; g++) hist[g] = '0;
        for (int g = 0; g < 128; g++) if (mem[g] !== hist[g]) bad++;
        check("ram_after_abort", bad, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero();
        rst = 1'b0;

        // All-zero histogram; then a start right after finish_clear.
        for (int g = 0; g < 128; g++) hist[g] = '0;
        load_hist();
        full_sweep(1'b0);
        abort_run(2);

        // Single bin at gray 10.
        for (int g = 0; g < 128; g++) hist[g] = '0;
        hist[10] = 20'd100;
        load_hist();
        full_sweep(1'b0);

        // Flat histogram with a spurious start mid-EMIT.
        for (int g = 0; g < 128; g++) hist[g] = 20'd1;
        load_hist();
        full_sweep(1'b1);

        // Random bins with a saturated top bin (gray-sum wrap).
        for (int g = 0; g < 128; g++) hist[g] = BIN_W'($urandom);
        hist[127] = 20'hFFFFF;
        load_hist();
        full_sweep(1'b0);

        // Random bins, aborted at window 40, then a fresh restart.
        for (int g = 0; g < 128; g++) hist[g] = BIN_W'($urandom_range(0, 4095));
        load_hist();
        abort_run(40);
        abort_run(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/otus_hist_scan.md
Name: otus_hist_scan

Overview:
- Feeder for the Otsu threshold DSP stage: after a frame's 128-bin gray histogram has been accumulated in an external RAM, this block sweeps every threshold T = 0..127.
- For each threshold it produces the cumulative pixel counts and cumulative gray-weighted sums on both sides of T, and presents them with a one-cycle dsp_vld at a fixed 128-cycle period.
- While sweeping, it zeroes each histogram bin. One cycle before the DSP's count would otherwise run past the end of the last threshold window, it issues the single finish_clear pulse that latches the threshold result and rearms the DSP.

Parameters:
- BIN_W, 20, width of one histogram bin / pixel count.
- GA_W, 23, width of gray-weighted sums; arithmetic is modulo 2^GA_W.
- PERIOD, 128, cycles between successive dsp_vld pulses. Fixed: must equal the DSP's free-running 7-bit cycle counter.

Ports:
- clock, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse at frame end; accepted only in IDLE.
- busy, out, 1, high from start acceptance through the finish_clear cycle inclusive.
- ram_rd_addr, out, 7, histogram read address; RAM read latency is 1 cycle.
- ram_rd_data, in, BIN_W, histogram bin value.
- ram_wr_en, out, 1, bin clear strobe.
- ram_wr_addr, out, 7, bin being cleared.
- ram_wr_data, out, BIN_W, constant 0.
- dsp_vld, out, 1, one-cycle pulse; data outputs are valid in this cycle.
- N1_u20, out, BIN_W, sum of hist[0..T].
- N2_u20, out, BIN_W, sum of hist[T+1..127].
- GrayAll1, out, GA_W, sum of hist[g]*g for g ≤ T.
- GrayAll2, out, GA_W, sum of hist[g]*g for g > T.
- finish_clear, out, 1, one-cycle pulse ending the sweep.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): state to IDLE. busy, dsp_vld, finish_clear and ram_wr_en go to 0. All data outputs and accumulators go to 0, and ram_rd_addr goes to 0.
- Reset mid-sweep aborts immediately. Bins not yet cleared keep their contents.
- States: IDLE → TOTAL → EMIT → TAIL → IDLE.
- IDLE: start=1 at cycle s moves to TOTAL.
- TOTAL:
  - ram_rd_addr = 0..127 on cycles s+1..s+128.
  - Each returned bin h at address g is accumulated: Ntot += h (mod 2^BIN_W), GAtot += h*g (mod 2^GA_W).
  - Last data arrives at s+129; EMIT begins at s+130.
- EMIT runs windows k = 0..127, each exactly PERIOD cycles. Window cycle c:
  - c=0: ram_rd_addr = k.
  - c=1: register h = ram_rd_data.
  - c=2: N1 += h; GA1 += h*k. Register outputs N1_u20 = N1, N2_u20 = Ntot − N1, GrayAll1 = GA1, GrayAll2 = GAtot − GA1 (subtractions modulo width). The product h*k is formed at full width, then truncated to GA_W.
  - c=3: dsp_vld = 1; ram_wr_en = 1, ram_wr_addr = k, ram_wr_data = 0.
  - Data outputs hold from c=2 of window k until c=2 of window k+1.
- Timing: the k-th dsp_vld is at s+133+128k. Exactly 128 pulses are issued; the last is at s+16389.
- TAIL:
  - finish_clear = 1 exactly 126 cycles after the 128th dsp_vld (s+16515). This is the DSP's final-window cycle-125 point.
  - busy drops to 0 the following cycle; return to IDLE.
- Simultaneous events:
  - start while busy is ignored.
  - rst together with start: reset wins.
  - start in the cycle after finish_clear is accepted.
- dsp_vld and finish_clear are never high in the same cycle.
- The read port is idle (address held) outside TOTAL and EMIT c=0.
- No bin is written outside EMIT c=3.

Test Plan:
- All bins 0, start → 128 dsp_vld pulses spaced 128 cycles, first at start+133, all data outputs 0. finish_clear at start+16515, busy low at start+16516.
- hist[10]=100, others 0 → T<10: N1=0, N2=100, GA1=0, GA2=1000. T≥10: N1=100, N2=0, GA1=1000, GA2=0.
- hist[g]=1 for all g → at T=63: N1=64, N2=64, GA1=2016, GA2=6112. At T=127: N1=128, N2=0, GA1=8128, GA2=0.
- After the sweep, read back the RAM → all 128 bins 0. Exactly 128 writes occur, addresses 0..127 in order, each 3 cycles after the window's read.
- hist[127]=2^20−1 → GAtot = (2^20−1)*127 mod 2^23. At T=126: GA2 equals that wrapped value.
- start pulse mid-EMIT → ignored, pulse count still 128. rst asserted at window 40 c=1 → next cycle all outputs 0 and state IDLE. A new start restarts at T=0 with fresh totals.
